// File: rtl/bottling_line_ctrl.sv
// bottling_line_ctrl: single-bottle fill/seal/QC sequencer with stage watchdogs, batch and reject counters
module bottling_line_ctrl #(
  parameter int FILL_TO    = 64,
  parameter int SEAL_TO    = 32,
  parameter int QC_TO      = 16,
  parameter int BATCH_SIZE = 12,
  parameter int MAX_REJ    = 3,
  parameter int CW         = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          run,
  input  logic          bottle,
  input  logic          level_ok,
  input  logic          seal_done,
  input  logic          qc_pass,
  input  logic          qc_fail,
  input  logic          alarm,
  input  logic          cnt_clr,
  input  logic          fault_clr,
  output logic          motor,
  output logic          valve,
  output logic          seal_en,
  output logic          qc_en,
  output logic          reject_en,
  output logic          batch_done,
  output logic [CW-1:0] accepted_cnt,
  output logic [CW-1:0] rejected_cnt,
  output logic          fault,
  output logic [2:0]    fault_code,
  output logic [2:0]    state_o
);
  localparam int TMAX = (FILL_TO > SEAL_TO) ? ((FILL_TO > QC_TO) ? FILL_TO : QC_TO)
                                            : ((SEAL_TO > QC_TO) ? SEAL_TO : QC_TO);
  localparam int TW = $clog2(TMAX + 1);
  localparam int SW = $clog2(MAX_REJ + 1);
  typedef enum logic [2:0] {
    IDLE = 3'd0, MOVE = 3'd1, FILL = 3'd2, SEAL = 3'd3,
    QC = 3'd4, COUNT = 3'd5, REJECT = 3'd6, FAULT = 3'd7
  } state_t;
  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [SW-1:0] streak_q, streak_d, streak_inc;
  logic [CW-1:0] acc_q, acc_d, rej_q, rej_d;
  logic [2:0]    code_q, code_d;
  logic          last_in_batch;
  assign streak_inc    = streak_q + 1'b1;
  assign last_in_batch = acc_q == CW'(BATCH_SIZE - 1);
  assign timer_d       = (state_d != state_q) ? '0 : timer_q + 1'b1;
  // state, stage watchdog timer, counters and latched fault cause
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      streak_q <= '0;
      acc_q    <= '0;
      rej_q    <= '0;
      code_q   <= '0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      streak_q <= streak_d;
      acc_q    <= acc_d;
      rej_q    <= rej_d;
      code_q   <= code_d;
    end
  end
  // sequencing: stage events win over watchdog expiry, run=0 aborts any active stage
  always_comb begin
    state_d  = state_q;
    streak_d = streak_q;
    acc_d    = acc_q;
    rej_d    = rej_q;
    code_d   = code_q;
    case (state_q)
      IDLE: begin
        state_d = run ? MOVE : IDLE;
        if (!run && cnt_clr) begin
          acc_d = '0;
          rej_d = '0;
        end
      end
      MOVE: state_d = (bottle && !alarm) ? FILL : MOVE;
      FILL: begin
        if (level_ok) state_d = SEAL;
        else if (timer_q == TW'(FILL_TO - 1)) begin
          state_d = FAULT;
          code_d  = 3'd1;
        end
      end
      SEAL: begin
        if (seal_done) state_d = QC;
        else if (timer_q == TW'(SEAL_TO - 1)) begin
          state_d = FAULT;
          code_d  = 3'd2;
        end
      end
      QC: begin
        if (qc_fail) state_d = REJECT;
        else if (qc_pass) state_d = COUNT;
        else if (timer_q == TW'(QC_TO - 1)) begin
          state_d = FAULT;
          code_d  = 3'd3;
        end
      end
      COUNT: begin
        state_d  = MOVE;
        streak_d = '0;
        acc_d    = last_in_batch ? '0 : acc_q + 1'b1;
      end
      REJECT: begin
        rej_d = (&rej_q) ? rej_q : rej_q + 1'b1;
        if (streak_inc == SW'(MAX_REJ)) begin
          streak_d = '0;
          state_d  = FAULT;
          code_d   = 3'd4;
        end else begin
          streak_d = streak_inc;
          state_d  = MOVE;
        end
      end
      FAULT: begin
        if (fault_clr && !run) begin
          state_d = IDLE;
          code_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (!run && state_q != IDLE && state_q != FAULT) begin
      state_d = IDLE;
      code_d  = code_q;
    end
  end
  assign motor        = (state_q == MOVE) && !alarm;
  assign valve        = state_q == FILL;
  assign seal_en      = state_q == SEAL;
  assign qc_en        = state_q == QC;
  assign reject_en    = state_q == REJECT;
  assign batch_done   = (state_q == COUNT) && last_in_batch;
  assign fault        = state_q == FAULT;
  assign accepted_cnt = acc_q;
  assign rejected_cnt = rej_q;
  assign fault_code   = code_q;
  assign state_o      = state_q;
endmodule
